// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt/ERET sequencer feeding the CP0 register file.
// Each accepted event runs IDLE -> WRITE -> REDIRECT and then returns to IDLE.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h8000_0180,
    parameter logic [31:0] REFILL_VECTOR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_exc_req,
    input  logic [4:0]  i_exc_code,
    input  logic [31:0] i_exc_pc,
    input  logic        i_exc_bd,
    input  logic        i_exc_has_bva,
    input  logic [31:0] i_exc_bva,
    input  logic        i_exc_refill,
    input  logic        i_eret_req,
    input  logic [5:0]  i_hw_int,
    input  logic [31:0] i_cp0_status,
    input  logic [31:0] i_cp0_epc,
    output logic [31:0] o_in_epc,
    output logic [31:0] o_in_status,
    output logic [31:0] o_in_cause,
    output logic [31:0] o_in_badVAddr,
    output logic        o_we_epc,
    output logic        o_we_status,
    output logic        o_we_cause,
    output logic        o_we_badVAddr,
    output logic        o_flush,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [5:0]  r_ip_meta;
    logic [5:0]  r_ip_sync;
    logic [31:0] r_target;

    logic        w_exl;
    logic        w_int_pend;
    logic        w_accept_exc;
    logic        w_accept_int;
    logic        w_accept_eret;
    logic        w_accept_trap;
    logic        w_bd;
    logic [4:0]  w_code;
    logic [31:0] w_cause;
    logic [31:0] w_epc_val;
    logic [31:0] w_target;

    assign w_exl      = i_cp0_status[1];
    assign w_int_pend = (|(r_ip_sync & i_cp0_status[15:10])) & i_cp0_status[0] & ~w_exl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ip_meta <= 6'd0;
            r_ip_sync <= 6'd0;
        end else begin
            r_ip_meta <= i_hw_int;
            r_ip_sync <= r_ip_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Acceptance is only possible in IDLE; exceptions beat interrupts beat ERET.
    always_comb begin
        w_next_state  = r_state;
        w_accept_exc  = 1'b0;
        w_accept_int  = 1'b0;
        w_accept_eret = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_exc_req) begin
                    w_accept_exc = 1'b1;
                    w_next_state = S_WRITE;
                end else if (w_int_pend) begin
                    w_accept_int = 1'b1;
                    w_next_state = S_WRITE;
                end else if (i_eret_req) begin
                    w_accept_eret = 1'b1;
                    w_next_state  = S_WRITE;
                end
            end
            S_WRITE:    w_next_state = S_REDIRECT;
            S_REDIRECT: w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // An interrupt is an exception with ExcCode 0, no delay slot and no bad address.
    assign w_accept_trap = w_accept_exc | w_accept_int;
    assign w_bd          = w_accept_exc & i_exc_bd;
    assign w_code        = w_accept_exc ? i_exc_code : 5'd0;
    assign w_cause       = {w_bd, 15'd0, r_ip_sync, 3'd0, w_code, 2'd0};
    assign w_epc_val     = w_bd ? (i_exc_pc - 32'd4) : i_exc_pc;

    always_comb begin
        w_target = EXC_VECTOR;
        if (w_accept_eret) begin
            w_target = i_cp0_epc;
        end else if (w_accept_exc && i_exc_refill && !w_exl) begin
            w_target = REFILL_VECTOR;
        end
    end

    // Update words and strobes are loaded at acceptance so they live exactly for WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_in_epc         <= 32'd0;
            o_in_status      <= 32'd0;
            o_in_cause       <= 32'd0;
            o_in_badVAddr    <= 32'd0;
            o_we_epc         <= 1'b0;
            o_we_status      <= 1'b0;
            o_we_cause       <= 1'b0;
            o_we_badVAddr    <= 1'b0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= 32'd0;
            r_target         <= 32'd0;
        end else begin
            o_in_epc         <= 32'd0;
            o_in_status      <= 32'd0;
            o_in_cause       <= 32'd0;
            o_in_badVAddr    <= 32'd0;
            o_we_epc         <= 1'b0;
            o_we_status      <= 1'b0;
            o_we_cause       <= 1'b0;
            o_we_badVAddr    <= 1'b0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= 32'd0;
            if (w_accept_trap) begin
                o_we_cause    <= 1'b1;
                o_in_cause    <= w_cause;
                o_we_status   <= 1'b1;
                o_in_status   <= i_cp0_status | 32'h0000_0002;
                o_we_epc      <= ~w_exl;
                o_in_epc      <= w_exl ? 32'd0 : w_epc_val;
                o_we_badVAddr <= w_accept_exc & i_exc_has_bva;
                o_in_badVAddr <= w_accept_exc ? i_exc_bva : 32'd0;
                r_target      <= w_target;
            end else if (w_accept_eret) begin
                o_we_status   <= 1'b1;
                o_in_status   <= i_cp0_status & ~32'h0000_0002;
                r_target      <= w_target;
            end
            if (r_state == S_WRITE) begin
                o_redirect_valid <= 1'b1;
                o_redirect_pc    <= r_target;
            end
        end
    end

    assign o_busy  = (r_state != S_IDLE);
    assign o_flush = (r_state != S_IDLE);

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed cases followed by random traffic,
// all compared against an event-level reference model.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        excReq;
    logic [4:0]  excCode;
    logic [31:0] excPc;
    logic        excBd;
    logic        excHasBva;
    logic [31:0] excBva;
    logic        excRefill;
    logic        eretReq;
    logic [5:0]  hwInt;
    logic [31:0] cp0Status;
    logic [31:0] cp0Epc;
    logic [31:0] inEpc, inStatus, inCause, inBadVAddr;
    logic        weEpc, weStatus, weCause, weBadVAddr;
    logic        flush, redirectValid, busy;
    logic [31:0] redirectPc;

    int testsRun;
    int testsFailed;

    // Reference model: phase counts observable busy cycles left (2 = WRITE, 1 = REDIRECT).
    int          phase;
    logic [5:0]  hwPrev1, hwPrev2;
    logic        expWeEpc, expWeCause, expWeBva;
    logic [31:0] expEpc, expStatus, expCause, expBva, expTarget;

    cp0_exc_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_exc_req        (excReq),
        .i_exc_code       (excCode),
        .i_exc_pc         (excPc),
        .i_exc_bd         (excBd),
        .i_exc_has_bva    (excHasBva),
        .i_exc_bva        (excBva),
        .i_exc_refill     (excRefill),
        .i_eret_req       (eretReq),
        .i_hw_int         (hwInt),
        .i_cp0_status     (cp0Status),
        .i_cp0_epc        (cp0Epc),
        .o_in_epc         (inEpc),
        .o_in_status      (inStatus),
        .o_in_cause       (inCause),
        .o_in_badVAddr    (inBadVAddr),
        .o_we_epc         (weEpc),
        .o_we_status      (weStatus),
        .o_we_cause       (weCause),
        .o_we_badVAddr    (weBadVAddr),
        .o_flush          (flush),
        .o_redirect_valid (redirectValid),
        .o_redirect_pc    (redirectPc),
        .o_busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic clearInputs();
        excReq = 1'b0; excCode = 5'd0; excPc = 32'd0; excBd = 1'b0;
        excHasBva = 1'b0; excBva = 32'd0; excRefill = 1'b0; eretReq = 1'b0;
        hwInt = 6'd0; cp0Status = 32'd0; cp0Epc = 32'd0;
    endtask

    // Compare every output against what the model says this cycle should show.
    task automatic checkAll();
        checkOutput("busy",  {31'd0, busy},  {31'd0, phase != 0});
        checkOutput("flush", {31'd0, flush}, {31'd0, phase != 0});
        if (phase == 2) begin
            checkOutput("we_status", {31'd0, weStatus}, 32'd1);
            checkOutput("in_status", inStatus, expStatus);
            checkOutput("we_cause", {31'd0, weCause}, {31'd0, expWeCause});
            checkOutput("we_epc", {31'd0, weEpc}, {31'd0, expWeEpc});
            checkOutput("we_badVAddr", {31'd0, weBadVAddr}, {31'd0, expWeBva});
            if (expWeCause) checkOutput("in_cause", inCause, expCause);
            if (expWeEpc)   checkOutput("in_epc", inEpc, expEpc);
            if (expWeBva)   checkOutput("in_badVAddr", inBadVAddr, expBva);
        end else begin
            checkOutput("strobes_idle", {28'd0, weEpc, weStatus, weCause, weBadVAddr}, 32'd0);
            checkOutput("in_idle", inEpc | inStatus | inCause | inBadVAddr, 32'd0);
        end
        checkOutput("redirect_valid", {31'd0, redirectValid}, {31'd0, phase == 1});
        if (phase == 1) checkOutput("redirect_pc", redirectPc, expTarget);
    endtask

    // Present the current inputs for one clock, advance the model, then check at the negedge.
    task automatic applyStimulus();
        logic exl, intPend;
        int   nextPhase;
        exl       = cp0Status[1];
        intPend   = ((hwPrev2 & cp0Status[15:10]) != 6'd0) && cp0Status[0] && !exl;
        nextPhase = (phase > 0) ? phase - 1 : 0;
        if (phase == 0 && (excReq || intPend || eretReq)) begin
            nextPhase = 2;
            if (excReq || intPend) begin
                expWeCause = 1'b1;
                expStatus  = cp0Status | 32'h2;
                expWeEpc   = !exl;
                if (excReq) begin
                    expCause  = (32'(excBd) << 31) + (32'(hwPrev2) << 10) + (32'(excCode) << 2);
                    expEpc    = excBd ? excPc - 32'd4 : excPc;
                    expWeBva  = excHasBva;
                    expBva    = excBva;
                    expTarget = (excRefill && !exl) ? 32'h8000_0000 : 32'h8000_0180;
                end else begin
                    expCause  = 32'(hwPrev2) << 10;
                    expEpc    = excPc;
                    expWeBva  = 1'b0;
                    expBva    = 32'd0;
                    expTarget = 32'h8000_0180;
                end
            end else begin
                expWeCause = 1'b0;
                expWeEpc   = 1'b0;
                expWeBva   = 1'b0;
                expStatus  = cp0Status & ~32'h2;
                expTarget  = cp0Epc;
            end
        end
        hwPrev2 = hwPrev1;
        hwPrev1 = hwInt;
        @(negedge clk);
        phase = nextPhase;
        checkAll();
    endtask

    task automatic doReset();
        clearInputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        phase = 0; hwPrev1 = 6'd0; hwPrev2 = 6'd0;
    endtask

    initial begin
        testsRun = 0; testsFailed = 0;
        expWeEpc = 0; expWeCause = 0; expWeBva = 0;
        expEpc = 0; expStatus = 0; expCause = 0; expBva = 0; expTarget = 0;
        doReset();
        checkAll();

        // Basic exception, EXL clear.
        excReq = 1; excCode = 5'd4; excPc = 32'h400; excHasBva = 1; excBva = 32'h1003;
        applyStimulus();
        checkOutput("spec_cause", inCause, 32'h10);
        checkOutput("spec_status", inStatus, 32'h2);
        clearInputs();
        applyStimulus();
        checkOutput("spec_redirect", redirectPc, 32'h8000_0180);
        applyStimulus();

        // Delay slot with EXL already set: no EPC write.
        excReq = 1; excCode = 5'd4; excPc = 32'h400; excBd = 1; excHasBva = 1; excBva = 32'h1003;
        cp0Status = 32'h2;
        applyStimulus();
        clearInputs();
        repeat (2) applyStimulus();

        // Refill vector selection depends on EXL.
        excReq = 1; excRefill = 1; excPc = 32'h500;
        applyStimulus();
        clearInputs();
        repeat (2) applyStimulus();
        excReq = 1; excRefill = 1; excPc = 32'h500; cp0Status = 32'h2;
        applyStimulus();
        clearInputs();
        repeat (2) applyStimulus();

        // Interrupt enabled, then with IE cleared.
        cp0Status = 32'h0401; hwInt = 6'd1; excPc = 32'h600;
        repeat (5) applyStimulus();
        clearInputs();
        repeat (3) applyStimulus();
        cp0Status = 32'h0400; hwInt = 6'd1;
        repeat (5) applyStimulus();
        clearInputs();
        repeat (3) applyStimulus();

        // ERET alone, ERET racing an exception, exception requests held through busy.
        eretReq = 1; cp0Epc = 32'h1234; cp0Status = 32'h3;
        applyStimulus();
        clearInputs();
        repeat (2) applyStimulus();
        eretReq = 1; cp0Epc = 32'h1234; excReq = 1; excCode = 5'd8; excPc = 32'h700;
        applyStimulus();
        excCode = 5'd9; excPc = 32'h800;
        repeat (4) applyStimulus();
        clearInputs();
        repeat (3) applyStimulus();

        // Reset asserted in the middle of WRITE.
        excReq = 1; excCode = 5'd5; excPc = 32'h900; excHasBva = 1; excBva = 32'h44;
        applyStimulus();
        clearInputs();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_strobes", {28'd0, weEpc, weStatus, weCause, weBadVAddr}, 32'd0);
        checkOutput("rst_busy", {30'd0, busy, flush}, 32'd0);
        checkOutput("rst_redirect", {31'd0, redirectValid}, 32'd0);
        checkOutput("rst_words", inEpc | inStatus | inCause | inBadVAddr | redirectPc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        phase = 0; hwPrev1 = 6'd0; hwPrev2 = 6'd0;
        applyStimulus();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            excReq    = ($urandom_range(0, 9) < 3);
            excCode   = 5'($urandom);
            excPc     = $urandom & 32'hFFFF_FFFC;
            excBd     = 1'($urandom);
            excHasBva = 1'($urandom);
            excBva    = $urandom;
            excRefill = 1'($urandom);
            eretReq   = ($urandom_range(0, 9) < 2);
            hwInt     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            cp0Status = $urandom;
            cp0Epc    = $urandom;
            applyStimulus();
        end
        clearInputs();
        repeat (3) applyStimulus();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
